// File: rtl/video_mono_pkg.sv
// Shared types and helpers for the monochrome luma colorizer.
// Mode/fade enums, scale range, RGB bundle and the scale multiply.
package video_mono_pkg;

  localparam int SCALE_MAX = 16;
  localparam int SCALE_W   = 5;

  typedef enum logic [2:0] {
    MODE_GREY    = 3'b000,
    MODE_GREEN   = 3'b001,
    MODE_AMBER   = 3'b010,
    MODE_BW      = 3'b011,
    MODE_RED     = 3'b100,
    MODE_BLUE    = 3'b101,
    MODE_FUCHSIA = 3'b110,
    MODE_PURPLE  = 3'b111
  } mono_mode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // (ch * sc) >> 4; sc <= 16 keeps the result within 8 bits
  function automatic logic [7:0] scale_ch(
    input logic [7:0]         ch,
    input logic [SCALE_W-1:0] sc
  );
    return 8'(({5'd0, ch} * {8'd0, sc}) >> 4);
  endfunction

endpackage

// File: rtl/video_mono_fade_ctrl.sv
// Vsync-timed mode controller: edge detect, frame counter, fade FSM.
// MONO_COLORIZER_FADE_EN selects the fade FSM; otherwise mode follows vsync.
module video_mono_fade_ctrl
  import video_mono_pkg::*;
#(
  parameter int FADE_STEP_FRAMES = 1
) (
  input  logic               clk_vid,
  input  logic               reset,
  input  logic               vsync,
  input  logic [2:0]         gfx_mode,
  output logic [SCALE_W-1:0] scale,
  output mono_mode_t         active_mode,
  output logic               busy
);

  localparam logic [SCALE_W-1:0] SMAX = SCALE_W'(SCALE_MAX);

  if (FADE_STEP_FRAMES < 1 || FADE_STEP_FRAMES > 15) begin : g_bad_step
    $error("FADE_STEP_FRAMES must be 1..15");
  end

  logic vsync_d;
  logic vs_rise;

  assign vs_rise = vsync & ~vsync_d;

  // vsync history, sampled every clock regardless of ce_pix
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) vsync_d <= 1'b0;
    else       vsync_d <= vsync;
  end

`ifdef MONO_COLORIZER_FADE_EN

  localparam logic [3:0] LAST = 4'(FADE_STEP_FRAMES - 1);

  fade_state_t        state, state_n;
  logic [SCALE_W-1:0] scale_n;
  mono_mode_t         mode_n;
  logic [3:0]         fcnt, fcnt_n;
  logic               match;
  logic               step;

  assign match = (gfx_mode == active_mode);
  assign step  = vs_rise && (fcnt == LAST);
  assign busy  = (state != IDLE);

  // fade state, scale, committed mode and frame counter
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      scale       <= SMAX;
      active_mode <= MODE_GREY;
      fcnt        <= '0;
    end else begin
      state       <= state_n;
      scale       <= scale_n;
      active_mode <= mode_n;
      fcnt        <= fcnt_n;
    end
  end

  // next state: direction follows this cycle's gfx_mode, steps on vsync
  always_comb begin
    state_n = state;
    scale_n = scale;
    mode_n  = active_mode;
    fcnt_n  = fcnt;
    unique case (state)
      IDLE: begin
        fcnt_n = '0;
        if (!match) state_n = FADE_OUT;
      end
      FADE_OUT: begin
        if (match) begin
          state_n = FADE_IN;
        end else if (scale == '0) begin
          state_n = SWITCH;
        end else if (step) begin
          fcnt_n  = '0;
          scale_n = scale - 1'b1;
          if (scale == SCALE_W'(1)) state_n = SWITCH;
        end else if (vs_rise) begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      SWITCH: begin
        fcnt_n = '0;
        if (vs_rise) begin
          mode_n  = mono_mode_t'(gfx_mode);
          state_n = FADE_IN;
        end
      end
      FADE_IN: begin
        if (!match) begin
          state_n = FADE_OUT;
        end else if (scale == SMAX) begin
          state_n = IDLE;
          fcnt_n  = '0;
        end else if (step) begin
          fcnt_n  = '0;
          scale_n = scale + 1'b1;
          if (scale == SMAX - 1'b1) state_n = IDLE;
        end else if (vs_rise) begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`else

  assign scale = SMAX;
  assign busy  = 1'b0;

  // mode switches cleanly at the start of each frame
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset)        active_mode <= MODE_GREY;
    else if (vs_rise) active_mode <= mono_mode_t'(gfx_mode);
  end

`endif

endmodule

// File: rtl/video_mono_colorizer.sv
// Luma to tinted RGB: tint stage then fade-scale stage, 2 ce_pix cycles.
// Fade sequencing on mode change requires MONO_COLORIZER_FADE_EN.
module video_mono_colorizer
  import video_mono_pkg::*;
#(
  parameter int         FADE_STEP_FRAMES = 1,
  parameter logic [7:0] GREEN_FLOOR      = 8'h0F,
  parameter logic [7:0] TINT_FLOOR       = 8'h08
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       vsync,
  input  logic [2:0] gfx_mode,
  input  logic [7:0] Y,
  output logic [7:0] R_OUT,
  output logic [7:0] G_OUT,
  output logic [7:0] B_OUT,
  output logic       busy
);

  logic [SCALE_W-1:0] scale;
  mono_mode_t         active_mode;
  logic [7:0]         flr, full, half;
  rgb_t               tint, s1, px;

  video_mono_fade_ctrl #(
    .FADE_STEP_FRAMES(FADE_STEP_FRAMES)
  ) u_fade (
    .clk_vid    (clk_vid),
    .reset      (reset),
    .vsync      (vsync),
    .gfx_mode   (gfx_mode),
    .scale      (scale),
    .active_mode(active_mode),
    .busy       (busy)
  );

  // per-mode tint of the incoming luma
  always_comb begin
    flr  = (active_mode == MODE_GREEN) ? GREEN_FLOOR : TINT_FLOOR;
    full = (Y > flr) ? Y : flr;
    half = {1'b0, Y[7:1]};
    tint = '{r: Y, g: Y, b: Y};
    unique case (active_mode)
      MODE_GREY:    tint = '{r: Y,    g: Y,    b: Y};
      MODE_GREEN:   tint = '{r: 8'd0, g: full, b: 8'd1};
      MODE_AMBER:   tint = '{r: full, g: half, b: 8'd1};
      MODE_BW:      tint = '{r: Y,    g: Y,    b: Y};
      MODE_RED:     tint = '{r: full, g: 8'd0, b: 8'd1};
      MODE_BLUE:    tint = '{r: 8'd0, g: half, b: full};
      MODE_FUCHSIA: tint = '{r: full, g: 8'd0, b: half};
      MODE_PURPLE:  tint = '{r: half, g: 8'd0, b: full};
      default:      tint = '{r: Y,    g: Y,    b: Y};
    endcase
  end

  // two-stage pixel pipeline, frozen while ce_pix is low
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      px <= '0;
    end else if (ce_pix) begin
      s1   <= tint;
      px.r <= scale_ch(s1.r, scale);
      px.g <= scale_ch(s1.g, scale);
      px.b <= scale_ch(s1.b, scale);
    end
  end

  assign R_OUT = px.r;
  assign G_OUT = px.g;
  assign B_OUT = px.b;

endmodule
